// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: Moore sequencer stepping the shared MIPS datapath through
// fetch/decode/execute/memory/writeback, with a memory ready handshake and retired count.
module mips_multicycle_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_iord,
  output logic             o_ir_write,
  output logic             o_pc_en,
  output logic [1:0]       o_pc_src,
  output logic             o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic             o_logic,
  output logic [1:0]       o_reg_dst,
  output logic [1:0]       o_mem_toreg,
  output logic             o_reg_write,
  output logic             o_mem_write,
  output logic             o_branch,
  output logic             o_illegal_op,
  output logic [3:0]       o_state,
  output logic [CNT_W-1:0] o_instr_count
);
  typedef enum logic [3:0] {
    S_FETCH = 4'd0, S_DECODE = 4'd1, S_MEMADR = 4'd2, S_MEMRD = 4'd3, S_MEMWB = 4'd4,
    S_MEMWR = 4'd5, S_RTEXE = 4'd6, S_ALUWB = 4'd7, S_BEQ = 4'd8, S_IMMEXE = 4'd9,
    S_IMMWB = 4'd10, S_JUMP = 4'd11, S_JAL = 4'd12
  } state_t;

  state_t           r_state, w_next;
  logic [CNT_W-1:0] r_count;
  logic             w_retire, w_ill, w_ori;

  assign w_ori         = i_opcode == 6'b001101;
  assign o_state       = r_state;
  assign o_instr_count = r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_FETCH;
      r_count <= '0;
    end else begin
      r_state <= w_next;
      if (w_retire) r_count <= r_count + CNT_W'(1);
    end
  end

  always_comb begin
    w_next   = S_FETCH;
    w_retire = 1'b0;
    w_ill    = 1'b0;
    case (r_state)
      S_FETCH:  w_next = i_mem_ready ? S_DECODE : S_FETCH;
      S_DECODE:
        case (i_opcode)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000:            w_next = S_RTEXE;
          6'b000100:            w_next = S_BEQ;
          6'b001000, 6'b001101: w_next = S_IMMEXE;
          6'b000010:            w_next = S_JUMP;
          6'b000011:            w_next = S_JAL;
          default:              w_ill  = 1'b1;
        endcase
      S_MEMADR: w_next = (i_opcode == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = i_mem_ready ? S_MEMWB : S_MEMRD;
      S_MEMWR: begin
        w_next   = i_mem_ready ? S_FETCH : S_MEMWR;
        w_retire = i_mem_ready;
      end
      S_RTEXE:  w_next = S_ALUWB;
      S_IMMEXE: w_next = S_IMMWB;
      S_MEMWB, S_ALUWB, S_BEQ, S_IMMWB, S_JUMP, S_JAL: w_retire = 1'b1;
      default:  w_next = S_FETCH;
    endcase
  end

  // Outputs are held at zero for as long as reset is asserted, even though the state is FETCH.
  always_comb begin
    o_mem_req    = 1'b0;
    o_iord       = 1'b0;
    o_ir_write   = 1'b0;
    o_pc_en      = 1'b0;
    o_pc_src     = 2'b00;
    o_alu_src_a  = 1'b0;
    o_alu_src_b  = 2'b00;
    o_alu_op     = 2'b00;
    o_logic      = 1'b0;
    o_reg_dst    = 2'b00;
    o_mem_toreg  = 2'b00;
    o_reg_write  = 1'b0;
    o_mem_write  = 1'b0;
    o_branch     = 1'b0;
    o_illegal_op = 1'b0;
    if (rst_n)
      case (r_state)
        S_FETCH: begin
          o_mem_req   = 1'b1;
          o_alu_src_b = 2'b01;
          o_ir_write  = i_mem_ready;
          o_pc_en     = i_mem_ready;
        end
        S_DECODE: begin
          o_alu_src_b  = 2'b11;
          o_illegal_op = w_ill;
        end
        S_MEMADR: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
        end
        S_MEMRD: begin
          o_mem_req = 1'b1;
          o_iord    = 1'b1;
        end
        S_MEMWB: begin
          o_mem_toreg = 2'b01;
          o_reg_write = 1'b1;
        end
        S_MEMWR: begin
          o_mem_req   = 1'b1;
          o_iord      = 1'b1;
          o_mem_write = 1'b1;
        end
        S_RTEXE: begin
          o_alu_src_a = 1'b1;
          o_alu_op    = 2'b10;
        end
        S_ALUWB: begin
          o_reg_dst   = 2'b01;
          o_reg_write = 1'b1;
        end
        S_BEQ: begin
          o_alu_src_a = 1'b1;
          o_alu_op    = 2'b01;
          o_branch    = 1'b1;
          o_pc_src    = 2'b01;
          o_pc_en     = i_zero;
        end
        S_IMMEXE: begin
          o_alu_src_a = 1'b1;
          o_alu_src_b = 2'b10;
          o_alu_op    = 2'b11;
          o_logic     = w_ori;
        end
        S_IMMWB: begin
          o_reg_write = 1'b1;
          o_logic     = w_ori;
        end
        S_JUMP: begin
          o_pc_src = 2'b10;
          o_pc_en  = 1'b1;
        end
        S_JAL: begin
          o_pc_src    = 2'b10;
          o_pc_en     = 1'b1;
          o_reg_write = 1'b1;
          o_reg_dst   = 2'b10;
          o_mem_toreg = 2'b10;
        end
        default: o_mem_req = 1'b0;
      endcase
  end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: directed instruction streams expanded into an expected per-cycle
// trace (state, outputs, retired count) checked against a 32-bit and a 2-bit-counter instance.
module tb_mips_multicycle_ctrl;
  typedef struct packed {
    logic mem_req, iord, ir_write, pc_en;
    logic [1:0] pc_src;
    logic a;
    logic [1:0] b, aop;
    logic lg;
    logic [1:0] dst, toreg;
    logic rw, mw, br, ill;
  } outs_t;

  typedef struct packed {
    logic rst_n, rdy, z;
    logic [5:0] op;
    logic [3:0] st;
    outs_t o;
    logic [31:0] cnt;
  } ent_t;

  localparam logic [5:0] LW = 6'h23, SW = 6'h2b, RT = 6'h00, BEQ = 6'h04, ADDI = 6'h08,
                         ORI = 6'h0d, J = 6'h02, JAL = 6'h03, BAD = 6'h3f;

  logic clk = 1'b0, rst_n = 1'b0, zero = 1'b0, mem_ready = 1'b1;
  logic [5:0] opcode = 6'h00;

  logic m1_mem_req, m1_iord, m1_ir_write, m1_pc_en, m1_a, m1_lg, m1_rw, m1_mw, m1_br, m1_ill;
  logic [1:0] m1_pc_src, m1_b, m1_aop, m1_dst, m1_toreg;
  logic [3:0] m1_state;
  logic [31:0] m1_cnt;
  logic m2_mem_req, m2_iord, m2_ir_write, m2_pc_en, m2_a, m2_lg, m2_rw, m2_mw, m2_br, m2_ill;
  logic [1:0] m2_pc_src, m2_b, m2_aop, m2_dst, m2_toreg;
  logic [3:0] m2_state;
  logic [1:0] m2_cnt;
  outs_t o1, o2;

  assign o1 = {m1_mem_req, m1_iord, m1_ir_write, m1_pc_en, m1_pc_src, m1_a, m1_b, m1_aop,
               m1_lg, m1_dst, m1_toreg, m1_rw, m1_mw, m1_br, m1_ill};
  assign o2 = {m2_mem_req, m2_iord, m2_ir_write, m2_pc_en, m2_pc_src, m2_a, m2_b, m2_aop,
               m2_lg, m2_dst, m2_toreg, m2_rw, m2_mw, m2_br, m2_ill};

  mips_multicycle_ctrl #(.CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_mem_req(m1_mem_req), .o_iord(m1_iord), .o_ir_write(m1_ir_write), .o_pc_en(m1_pc_en),
    .o_pc_src(m1_pc_src), .o_alu_src_a(m1_a), .o_alu_src_b(m1_b), .o_alu_op(m1_aop),
    .o_logic(m1_lg), .o_reg_dst(m1_dst), .o_mem_toreg(m1_toreg), .o_reg_write(m1_rw),
    .o_mem_write(m1_mw), .o_branch(m1_br), .o_illegal_op(m1_ill), .o_state(m1_state),
    .o_instr_count(m1_cnt)
  );

  mips_multicycle_ctrl #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .i_opcode(opcode), .i_zero(zero), .i_mem_ready(mem_ready),
    .o_mem_req(m2_mem_req), .o_iord(m2_iord), .o_ir_write(m2_ir_write), .o_pc_en(m2_pc_en),
    .o_pc_src(m2_pc_src), .o_alu_src_a(m2_a), .o_alu_src_b(m2_b), .o_alu_op(m2_aop),
    .o_logic(m2_lg), .o_reg_dst(m2_dst), .o_mem_toreg(m2_toreg), .o_reg_write(m2_rw),
    .o_mem_write(m2_mw), .o_branch(m2_br), .o_illegal_op(m2_ill), .o_state(m2_state),
    .o_instr_count(m2_cnt)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  ent_t q[$];
  ent_t cur;
  logic cur_valid = 1'b0;
  logic [31:0] m_cnt = 0;
  logic [5:0] g_op;
  logic g_z;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Output rules for one cycle spent in a given state, taken from the state descriptions.
  function automatic outs_t exp_out(input int st, input logic [5:0] op, input logic z,
                                    input logic rdy);
    outs_t o = '0;
    case (st)
      0:  begin o.mem_req = 1; o.b = 2'b01; o.ir_write = rdy; o.pc_en = rdy; end
      1:  begin
            o.b = 2'b11;
            o.ill = !(op inside {LW, SW, RT, BEQ, ADDI, ORI, J, JAL});
          end
      2:  begin o.a = 1; o.b = 2'b10; end
      3:  begin o.mem_req = 1; o.iord = 1; end
      4:  begin o.toreg = 2'b01; o.rw = 1; end
      5:  begin o.mem_req = 1; o.iord = 1; o.mw = 1; end
      6:  begin o.a = 1; o.aop = 2'b10; end
      7:  begin o.dst = 2'b01; o.rw = 1; end
      8:  begin o.a = 1; o.aop = 2'b01; o.br = 1; o.pc_src = 2'b01; o.pc_en = z; end
      9:  begin o.a = 1; o.b = 2'b10; o.aop = 2'b11; o.lg = (op == ORI); end
      10: begin o.rw = 1; o.lg = (op == ORI); end
      11: begin o.pc_src = 2'b10; o.pc_en = 1; end
      12: begin o.pc_src = 2'b10; o.pc_en = 1; o.rw = 1; o.dst = 2'b10; o.toreg = 2'b10; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic push(input int st, input logic rdy, input logic ret);
    ent_t e;
    e.rst_n = 1'b1; e.rdy = rdy; e.z = g_z; e.op = g_op; e.st = 4'(st);
    e.o = exp_out(st, g_op, g_z, rdy);
    e.cnt = m_cnt;
    q.push_back(e);
    if (ret) m_cnt++;
  endtask

  task automatic push_rst(input int n);
    ent_t e = '0;
    m_cnt = 0;
    e.rdy = 1'b1;
    for (int i = 0; i < n; i++) q.push_back(e);
  endtask

  // One instruction: fw wait cycles in FETCH, mw wait cycles in its memory state.
  task automatic add(input logic [5:0] op, input logic z, input int fw, input int mw);
    g_op = op; g_z = z;
    for (int i = 0; i < fw; i++) push(0, 1'b0, 1'b0);
    push(0, 1'b1, 1'b0);
    push(1, 1'b1, 1'b0);
    case (op)
      LW: begin
        push(2, 1, 0);
        for (int i = 0; i < mw; i++) push(3, 1'b0, 1'b0);
        push(3, 1, 0); push(4, 1, 1);
      end
      SW: begin
        push(2, 1, 0);
        for (int i = 0; i < mw; i++) push(5, 1'b0, 1'b0);
        push(5, 1, 1);
      end
      RT:        begin push(6, 1, 0); push(7, 1, 1); end
      BEQ:       push(8, 1, 1);
      ADDI, ORI: begin push(9, 1, 0); push(10, 1, 1); end
      J:         push(11, 1, 1);
      JAL:       push(12, 1, 1);
      default:   ;
    endcase
  endtask

  task automatic pad();
    g_op = RT; g_z = 1'b0;
    push(0, 1'b0, 1'b0);
  endtask

  task automatic run_q();
    while (q.size() > 0) begin
      @(posedge clk);
      #1;
      cur = q.pop_front();
      rst_n = cur.rst_n; mem_ready = cur.rdy; zero = cur.z; opcode = cur.op;
      cur_valid = 1'b1;
    end
    @(negedge clk);
    #1;
  endtask

  always @(negedge clk)
    if (cur_valid) begin
      chk("state", {28'd0, m1_state}, {28'd0, cur.st});
      chk("outputs", {12'd0, o1}, {12'd0, cur.o});
      chk("instr_count", m1_cnt, cur.cnt);
      chk("state_w2", {28'd0, m2_state}, {28'd0, cur.st});
      chk("outputs_w2", {12'd0, o2}, {12'd0, cur.o});
      chk("instr_count_w2", {30'd0, m2_cnt}, {30'd0, cur.cnt[1:0]});
    end

  initial begin
    push_rst(2);
    add(LW, 0, 0, 0); add(SW, 0, 0, 0); add(RT, 0, 0, 0); add(BEQ, 0, 0, 0); add(J, 0, 0, 0);
    pad();
    run_q();
    chk("lit_count_after_stream", m1_cnt, 32'd5);
    chk("lit_count_w2_after_stream", {30'd0, m2_cnt}, 32'd1);

    add(BEQ, 1, 0, 0); add(BEQ, 0, 0, 0);
    add(LW, 0, 3, 0); add(SW, 0, 0, 3);
    add(BAD, 0, 0, 0);
    add(ORI, 0, 0, 0); add(ADDI, 0, 0, 0); add(JAL, 0, 0, 0);
    pad();
    run_q();
    chk("lit_count_after_mix", m1_cnt, 32'd12);
    chk("lit_count_w2_wrapped", {30'd0, m2_cnt}, 32'd0);

    g_op = LW; g_z = 1'b0;
    push(0, 1, 0); push(1, 1, 0); push(2, 1, 0); push(3, 1'b0, 1'b0);
    push_rst(2);
    run_q();
    chk("lit_state_in_reset", {28'd0, m1_state}, 32'd0);
    chk("lit_count_in_reset", m1_cnt, 32'd0);
    chk("lit_mem_req_in_reset", {31'd0, m1_mem_req}, 32'd0);

    add(J, 0, 0, 0); add(JAL, 0, 0, 0); add(RT, 0, 0, 0); add(ADDI, 0, 0, 0);
    pad();
    run_q();
    chk("lit_count_after_four", m1_cnt, 32'd4);
    chk("lit_count_w2_four_wraps", {30'd0, m2_cnt}, 32'd0);

    cur_valid = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle sequencer for the MIPS core: replaces single-cycle main decoding with a Moore FSM that steps the shared datapath (one ALU, one unified memory port, register file) through fetch, decode, execute, memory and writeback cycles. It supports R-type, lw, sw, beq, addi, ori, j and jal, stalls on a ready/request handshake with unified memory, and counts retired instructions. It sits between the instruction register/ALU flags and every datapath mux and enable.

## Interface
- CNT_W, 32, width of retired-instruction counter
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]; stable from DECODE until the next FETCH completes
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access requested
- iord  out  1  memory address: 0 = PC, 1 = ALUOut
- ir_write  out  1  load IR
- pc_en  out  1  PC write enable
- pc_src  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- alu_src_a  out  1  0 = PC, 1 = register A
- alu_src_b  out  2  00 reg B, 01 constant 4, 10 sign-extended imm, 11 imm<<2
- alu_op  out  2  00 add, 01 sub, 10 funct, 11 immediate
- logic  out  1  zero-extend immediate (ori)
- reg_dst  out  2  00 rt, 01 rd, 10 $31
- mem_toreg  out  2  00 ALUOut, 01 memory data, 10 PC
- reg_write  out  1  register file write
- mem_write  out  1  memory write
- branch  out  1  beq compare cycle
- illegal_op  out  1  one-cycle pulse on unsupported opcode
- state  out  4  current state code (for debug/verification)
- instr_count  out  CNT_W  retired instructions, wraps modulo 2^CNT_W

## Operation
- States/codes: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, RTEXE 6, ALUWB 7, BEQ 8, IMMEXE 9, IMMWB 10, JUMP 11, JAL 12; codes 13-15 unreachable and map to FETCH.
- All outputs are decoded from state (plus mem_ready, zero, opcode where noted); any signal not listed for a state is 0.
- FETCH: mem_req=1, alu_src_b=01; ir_write=pc_en=mem_ready. Stay until mem_ready, then DECODE.
- DECODE: alu_src_b=11. Next state by opcode: 100011/101011 -> MEMADR, 000000 -> RTEXE, 000100 -> BEQ, 001000/001101 -> IMMEXE, 000010 -> JUMP, 000011 -> JAL, any other -> FETCH with illegal_op=1. Illegal opcodes are not counted.
- MEMADR: alu_src_a=1, alu_src_b=10; lw -> MEMRD, sw -> MEMWR.
- MEMRD: mem_req=1, iord=1; wait for mem_ready, then MEMWB. MEMWB: mem_toreg=01, reg_write=1 -> FETCH.
- MEMWR: mem_req=1, iord=1, mem_write=1, held until mem_ready, then FETCH.
- RTEXE: alu_src_a=1, alu_op=10 -> ALUWB. ALUWB: reg_dst=01, reg_write=1 -> FETCH.
- BEQ: alu_src_a=1, alu_op=01, branch=1, pc_src=01, pc_en=zero -> FETCH.
- IMMEXE: alu_src_a=1, alu_src_b=10, alu_op=11 -> IMMWB. IMMWB: reg_write=1 -> FETCH. logic=(opcode==001101) in both states.
- JUMP: pc_src=10, pc_en=1 -> FETCH. JAL: pc_src=10, pc_en=1, reg_write=1, reg_dst=10, mem_toreg=10 -> FETCH.
- instr_count increments by 1 on each clock edge that leaves MEMWB, MEMWR (with mem_ready), ALUWB, BEQ, IMMWB, JUMP or JAL.

## Timing
- Reset: state=FETCH, instr_count=0. While rst_n=0, every output is forced to 0 (state reads 0). Reset mid-instruction aborts it without counting it. The first FETCH begins on the first edge after rst_n rises.
- Cycles with a zero-wait memory: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j/jal 3, illegal 2. Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- While waiting, all outputs stay constant; mem_write must not drop before mem_ready.
- instr_count wraps from 2^CNT_W-1 to 0 with no flag.

## Test plan
- Reset with mem_ready=1, then a stream lw, sw, add, beq, j -> state sequences 0,1,2,3,4 / 0,1,2,5 / 0,1,6,7 / 0,1,8 / 0,1,11; instr_count=5 after 19 cycles.
- beq with zero=1 and then zero=0 -> pc_en=1, pc_src=01 in the first BEQ cycle; pc_en=0 in the second.
- FETCH with mem_ready low for 3 cycles -> mem_req=1 and ir_write=pc_en=0 for 3 cycles, then ir_write=pc_en=1 for one cycle. Same check for MEMWR: mem_write is held for 4 cycles.
- opcode 111111 -> illegal_op pulse in DECODE, return to FETCH, instr_count unchanged. ori -> logic=1 and alu_op=11 in IMMEXE/IMMWB; addi -> logic=0.
- jal -> in JAL: reg_dst=10, mem_toreg=10, reg_write=1, pc_src=10, pc_en=1.
- rst_n low during MEMRD -> outputs 0 immediately; after release, state=0 and instr_count=0. Preload-free wrap check with CNT_W=2: after 4 retirements, instr_count=0.
